// File: rtl/mux_stim_gen_if.sv
// Signal bundle between the stimulus generator and whatever drives/observes it.
// The master modport is the controller side, the slave modport is the generator.
interface mux_stim_gen_if;
    logic        start;
    logic        stop;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        in_1;
    logic        in_2;
    logic        sel;
    logic        stim_vld;
    logic        busy;
    logic        done;
    logic [15:0] step_cnt;

    modport master (
        output start,
        output stop,
        output seed_load,
        output seed_in,
        input  in_1,
        input  in_2,
        input  sel,
        input  stim_vld,
        input  busy,
        input  done,
        input  step_cnt
    );

    modport slave (
        input  start,
        input  stop,
        input  seed_load,
        input  seed_in,
        output in_1,
        output in_2,
        output sel,
        output stim_vld,
        output busy,
        output done,
        output step_cnt
    );
endinterface

// File: rtl/mux_stim_gen.sv
// LFSR-driven stimulus generator for a downstream 2:1 mux: every CNT_MAX clocks
// in RUN it issues a new {in_1, in_2, sel} vector with a one-clock valid strobe.
module mux_stim_gen #(
    parameter int          CNT_MAX = 10,
    parameter int          STEPS   = 0,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    mux_stim_gen_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [15:0] CNT_LAST   = 16'(CNT_MAX - 1);
    localparam logic [15:0] STEPS_W    = 16'(STEPS);
    localparam logic [15:0] SAFE_SEED  = 16'hACE1;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_lfsr;
    logic        r_in1;
    logic        r_in2;
    logic        r_sel;
    logic        r_stimVld;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_stepCnt;

    logic        w_fb;
    logic [15:0] w_lfsrNext;
    logic        w_tick;
    logic [15:0] w_stepNext;
    logic [15:0] w_loadSeed;

    assign w_fb       = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_lfsrNext = {r_lfsr[14:0], w_fb};
    assign w_tick     = (r_state == RUN) && (r_cnt == CNT_LAST);
    assign w_stepNext = r_stepCnt + 16'd1;
    // A zero seed would lock the LFSR up, so it is replaced with a known-good value.
    assign w_loadSeed = (bus.seed_in == 16'd0) ? SAFE_SEED : bus.seed_in;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= 16'd0;
            r_lfsr    <= SEED;
            r_in1     <= 1'b0;
            r_in2     <= 1'b0;
            r_sel     <= 1'b0;
            r_stimVld <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_stepCnt <= 16'd0;
        end else begin
            r_stimVld <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.seed_load) begin
                        r_lfsr <= w_loadSeed;
                    end
                    if (bus.start && !bus.stop) begin
                        r_state   <= RUN;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_cnt     <= 16'd0;
                        r_stepCnt <= 16'd0;
                    end
                end

                RUN: begin
                    // Stop has priority and also swallows a tick landing on the same edge.
                    if (bus.stop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_cnt   <= 16'd0;
                    end else if (w_tick) begin
                        r_cnt     <= 16'd0;
                        r_lfsr    <= w_lfsrNext;
                        r_in1     <= w_lfsrNext[0];
                        r_in2     <= w_lfsrNext[1];
                        r_sel     <= w_lfsrNext[2];
                        r_stimVld <= 1'b1;
                        r_stepCnt <= w_stepNext;
                        if ((STEPS != 0) && (w_stepNext == STEPS_W)) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                DONE: begin
                    if (bus.stop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else if (bus.start) begin
                        r_state   <= RUN;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_cnt     <= 16'd0;
                        r_stepCnt <= 16'd0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_cnt   <= 16'd0;
                end
            endcase
        end
    end

    assign bus.in_1     = r_in1;
    assign bus.in_2     = r_in2;
    assign bus.sel      = r_sel;
    assign bus.stim_vld = r_stimVld;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.step_cnt = r_stepCnt;

endmodule

// File: tb/tb_mux_stim_gen.sv
// Scoreboard bench for mux_stim_gen: an unlimited-run instance driven with random
// runs, plus a STEPS=3 instance for the finite-run behaviour.
module tb_mux_stim_gen;

    localparam int          CNT_MAX = 10;
    localparam logic [15:0] SEED    = 16'hACE1;

    typedef struct {
        int          cyc;
        logic        in1;
        logic        in2;
        logic        sel;
        logic [15:0] step;
    } exp_t;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    int   cyc  = 0;
    int   checks = 0;
    int   errors = 0;
    int   cnt3 = 0;
    exp_t sb[$];
    exp_t monE;
    logic [15:0] mLfsr = SEED;
    logic [15:0] m3Lfsr = SEED;

    mux_stim_gen_if ifc ();
    mux_stim_gen_if ifc3 ();

    mux_stim_gen #(.CNT_MAX(CNT_MAX), .STEPS(0), .SEED(SEED)) dut (
        .sys_clk  (clk),
        .sys_rst_n(rstN),
        .bus      (ifc)
    );

    mux_stim_gen #(.CNT_MAX(CNT_MAX), .STEPS(3), .SEED(SEED)) dut3 (
        .sys_clk  (clk),
        .sys_rst_n(rstN),
        .bus      (ifc3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] lfsrNext(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tickClk();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic sp, input logic ld, input logic [15:0] sd);
        ifc.start     = st;
        ifc.stop      = sp;
        ifc.seed_load = ld;
        ifc.seed_in   = sd;
        tickClk();
        ifc.start     = 1'b0;
        ifc.stop      = 1'b0;
        ifc.seed_load = 1'b0;
    endtask

    // Each strobe of the main instance is matched against the oldest expected vector.
    always @(negedge clk) begin
        if (rstN && ifc.stim_vld) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedStrobe: got strobe at cycle %0d, required none", cyc);
            end else begin
                monE = sb.pop_front();
                checkOutput("strobeCycle", cyc, monE.cyc);
                checkOutput("vector", {ifc.in_1, ifc.in_2, ifc.sel}, {monE.in1, monE.in2, monE.sel});
                checkOutput("stepCnt", ifc.step_cnt, monE.step);
            end
        end
    end

    always @(negedge clk) begin
        if (rstN && ifc3.stim_vld) cnt3++;
    end

    task automatic runVectors(input int n, input bit loadSeed, input logic [15:0] seed,
                              input bit withStart, input bit stopOnTick, input bit midLoad);
        exp_t e;
        int   c;
        if (loadSeed && !withStart) begin
            applyStimulus(1'b0, 1'b0, 1'b1, seed);
            mLfsr = (seed == 16'd0) ? 16'hACE1 : seed;
        end
        ifc.start = 1'b1;
        if (loadSeed && withStart) begin
            ifc.seed_load = 1'b1;
            ifc.seed_in   = seed;
            mLfsr = (seed == 16'd0) ? 16'hACE1 : seed;
        end
        c = cyc;
        for (int k = 1; k <= n; k++) begin
            mLfsr  = lfsrNext(mLfsr);
            e.cyc  = c + 1 + CNT_MAX * k;
            e.in1  = mLfsr[0];
            e.in2  = mLfsr[1];
            e.sel  = mLfsr[2];
            e.step = 16'(k);
            sb.push_back(e);
        end
        tickClk();
        ifc.start     = 1'b0;
        ifc.seed_load = 1'b0;
        for (int i = 0; i < CNT_MAX * n; i++) begin
            ifc.seed_load = midLoad && (i == 3);
            ifc.seed_in   = 16'h1234;
            tickClk();
        end
        ifc.seed_load = 1'b0;
        if (stopOnTick) repeat (CNT_MAX - 1) tickClk();
        ifc.stop = 1'b1;
        tickClk();
        ifc.stop = 1'b0;
        repeat (2) tickClk();
        checkOutput("sbDrain", sb.size(), 0);
        sb.delete();
        checkOutput("busyAfterStop", ifc.busy, 0);
        checkOutput("doneAfterStop", ifc.done, 0);
        checkOutput("stepHold", ifc.step_cnt, n);
        checkOutput("vectorHold", {ifc.in_1, ifc.in_2, ifc.sel}, {mLfsr[0], mLfsr[1], mLfsr[2]});
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        int   c;
        ifc.start = 0;  ifc.stop = 0;  ifc.seed_load = 0;  ifc.seed_in = 0;
        ifc3.start = 0; ifc3.stop = 0; ifc3.seed_load = 0; ifc3.seed_in = 0;
        #1;
        checkOutput("rstOutputs", {ifc.in_1, ifc.in_2, ifc.sel, ifc.stim_vld, ifc.busy, ifc.done}, 0);
        repeat (3) tickClk();
        checkOutput("rstStep", ifc.step_cnt, 0);
        checkOutput("rstOutputs3", {ifc3.in_1, ifc3.in_2, ifc3.sel, ifc3.stim_vld, ifc3.busy, ifc3.done}, 0);
        rstN = 1'b1;
        tickClk();

        // Finite run: three strobes, then DONE holding the last vector.
        ifc3.start = 1'b1;
        tickClk();
        ifc3.start = 1'b0;
        repeat (40) tickClk();
        repeat (3) m3Lfsr = lfsrNext(m3Lfsr);
        checkOutput("s3Count", cnt3, 3);
        checkOutput("s3Step", ifc3.step_cnt, 3);
        checkOutput("s3Done", ifc3.done, 1);
        checkOutput("s3Busy", ifc3.busy, 0);
        checkOutput("s3Vector", {ifc3.in_1, ifc3.in_2, ifc3.sel}, {m3Lfsr[0], m3Lfsr[1], m3Lfsr[2]});
        repeat (20) tickClk();
        checkOutput("s3HoldCount", cnt3, 3);
        checkOutput("s3HoldVector", {ifc3.in_1, ifc3.in_2, ifc3.sel}, {m3Lfsr[0], m3Lfsr[1], m3Lfsr[2]});
        ifc3.start = 1'b1;
        tickClk();
        ifc3.start = 1'b0;
        repeat (40) tickClk();
        repeat (3) m3Lfsr = lfsrNext(m3Lfsr);
        checkOutput("s3RestartCount", cnt3, 6);
        checkOutput("s3RestartDone", ifc3.done, 1);
        checkOutput("s3RestartVector", {ifc3.in_1, ifc3.in_2, ifc3.sel}, {m3Lfsr[0], m3Lfsr[1], m3Lfsr[2]});
        ifc3.stop = 1'b1;
        tickClk();
        ifc3.stop = 1'b0;
        tickClk();
        checkOutput("s3StopDone", ifc3.done, 0);
        checkOutput("s3StopBusy", ifc3.busy, 0);

        runVectors(2, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("firstRunSecondVec", {ifc.in_1, ifc.in_2, ifc.sel}, 3'b111);

        runVectors(1, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("zeroSeedVec", {ifc.in_1, ifc.in_2, ifc.sel}, 3'b110);

        runVectors(2, 1'b1, 16'h0, 1'b1, 1'b1, 1'b0);
        runVectors(3, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
        tickClk();
        checkOutput("startStopBusy", ifc.busy, 0);

        // Asynchronous reset in the middle of a run, between clock edges.
        ifc.start = 1'b1;
        c = cyc;
        for (int k = 1; k <= 2; k++) begin
            mLfsr  = lfsrNext(mLfsr);
            e.cyc  = c + 1 + CNT_MAX * k;
            e.in1  = mLfsr[0];
            e.in2  = mLfsr[1];
            e.sel  = mLfsr[2];
            e.step = 16'(k);
            sb.push_back(e);
        end
        tickClk();
        ifc.start = 1'b0;
        repeat (25) tickClk();
        @(posedge clk);
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("asyncRstOutputs", {ifc.in_1, ifc.in_2, ifc.sel, ifc.stim_vld, ifc.busy, ifc.done}, 0);
        checkOutput("asyncRstStep", ifc.step_cnt, 0);
        checkOutput("asyncRstDrain", sb.size(), 0);
        sb.delete();
        repeat (2) tickClk();
        rstN  = 1'b1;
        mLfsr = SEED;
        repeat (30) tickClk();
        checkOutput("postRstBusy", ifc.busy, 0);
        checkOutput("postRstStep", ifc.step_cnt, 0);

        for (int r = 0; r < 10; r++) begin
            runVectors(int'($urandom_range(1, 4)),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
                       1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_stim_gen.md
MUX_STIM_GEN -- requirements
Module: mux_stim_gen

Interface
REQ-001 Parameter CNT_MAX, default 10: the number of clocks between successive stimulus vectors; legal range 2..65535.
REQ-002 Parameter STEPS, default 0: the number of vectors per run; 0 means unlimited.
REQ-003 Parameter SEED, default 16'hACE1: the LFSR reset value; it shall be nonzero.
REQ-004 sys_clk  in  1  single clock; all state changes on its rising edge.
REQ-005 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  level-sampled request to begin or restart a run.
REQ-007 stop  in  1  level-sampled request to abort a run.
REQ-008 seed_load  in  1  loads seed_in into the LFSR.
REQ-009 seed_in  in  16  new LFSR seed.
REQ-010 in_1  out  1  stimulus data input 1 to the downstream 2:1 mux.
REQ-011 in_2  out  1  stimulus data input 2 to the downstream 2:1 mux.
REQ-012 sel  out  1  stimulus select to the downstream 2:1 mux.
REQ-013 stim_vld  out  1  one-clock strobe marking a new vector on in_1/in_2/sel.
REQ-014 busy  out  1  high while in state RUN.
REQ-015 done  out  1  high while in state DONE.
REQ-016 step_cnt  out  16  number of vectors issued in the current run.

Function
REQ-017 The FSM shall have exactly three states: IDLE, RUN and DONE.
REQ-018 State transitions shall be:
- IDLE->RUN on start.
- RUN->IDLE on stop.
- RUN->DONE when step_cnt reaches STEPS (STEPS!=0).
- DONE->RUN on start.
- DONE->IDLE on stop.
REQ-019 If start and stop are high in the same cycle, stop shall win.
REQ-020 On entry to RUN, the divider cnt and step_cnt shall be cleared to 0.
REQ-021 The LFSR shall not be reseeded on entry to RUN; it continues from its current value.
REQ-022 In RUN, cnt shall increment every clock and wrap to 0 at CNT_MAX-1.
REQ-023 The LFSR shall be 16-bit Fibonacci: fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}.
REQ-024 The LFSR shall advance only on a RUN clock with cnt==CNT_MAX-1 (the tick).
REQ-025 On each tick, in_1/in_2/sel shall be registered from bits [0]/[1]/[2] of the next LFSR value.
REQ-026 On each tick, stim_vld shall go high for exactly the following clock.
REQ-027 On each tick, step_cnt shall increment by 1.
REQ-028 First-vector latency: stim_vld shall first go high CNT_MAX clocks after the edge that accepts start.
REQ-029 Subsequent vectors shall be exactly CNT_MAX clocks apart.
REQ-030 The DONE transition shall occur on the tick that makes step_cnt equal STEPS; that vector's stim_vld shall still be issued.
REQ-031 With STEPS=0, step_cnt shall wrap from 16'hFFFF to 0 and the run shall continue.
REQ-032 In IDLE and DONE, in_1/in_2/sel and step_cnt shall hold their last values, and stim_vld shall be 0.
REQ-033 seed_load shall be honoured only in IDLE; it is ignored in RUN and DONE.
REQ-034 If seed_in==0 at load, the LFSR shall load 16'hACE1 instead, so the all-zero lock-up state is never entered.
REQ-035 If seed_load and start occur in the same IDLE cycle, the seed shall load and RUN shall be entered; the first vector derives from the new seed.
REQ-036 A stop on a tick cycle shall suppress that tick: no LFSR advance, no stim_vld, no step_cnt change.

Reset
REQ-037 While sys_rst_n is low, the block shall immediately force:
- state IDLE, cnt 0, LFSR SEED;
- in_1/in_2/sel 0, stim_vld 0, busy 0, done 0, step_cnt 0.
REQ-038 Reset asserted mid-run shall abort the run with no further stim_vld; after release the block remains in IDLE until start.

Verification
REQ-039 Bench scenarios (default parameters):
- Reset, start pulse -> stim_vld at start+10 clocks with in_1=1, in_2=1, sel=0 (LFSR 16'h59C3); next strobe 10 clocks later with 1,1,1 (16'hB387).
- STEPS=3, start -> exactly 3 stim_vld strobes, step_cnt=3, done=1, busy=0; outputs hold afterwards.
- Stop asserted on a tick cycle -> no strobe, state IDLE, step_cnt unchanged.
- seed_load with seed_in=0 in IDLE, then start -> first vector equals the vector from seed ACE1 (1,1,0).
- seed_load in RUN with seed_in=16'h1234 -> ignored; vector sequence unchanged.
- sys_rst_n pulsed low mid-run, asynchronously between clock edges -> all outputs 0 at once, state IDLE, no strobe until the next start.
